// File: rtl/to_rec_fn_pkg.sv
// Shared constants for the binary32 -> recoded-format converter.
package to_rec_fn_pkg;
   localparam int EXP_W     = 8;
   localparam int FRAC_W    = 23;
   localparam int REC_EXP_W = 9;

   localparam logic [REC_EXP_W-1:0] REC_BIAS_ADJ = 9'h081;
   localparam logic [REC_EXP_W-1:0] REC_EXP_INF  = 9'h180;
   localparam logic [REC_EXP_W-1:0] REC_EXP_NAN  = 9'h1C0;
   localparam logic [31:0]          CANON_NAN_SIG = 32'hC0000000;
endpackage

// File: rtl/to_rec_fn_lzc.sv
// Leading-zero count of a 23-bit fraction; an all-zero input reports FRAC_W.
module to_rec_fn_lzc
   import to_rec_fn_pkg::*;
(
   input  logic [FRAC_W-1:0] f,
   output logic [4:0]        cnt
);

   // Later (higher) set bits overwrite, so the most significant one wins.
   always_comb begin
      cnt = 5'(FRAC_W);
      for (int i = 0; i < FRAC_W; i++) begin
         if (f[i]) cnt = 5'(FRAC_W - 1 - i);
      end
   end

endmodule

// File: rtl/to_rec_fn.sv
// IEEE binary32 to recoded exponent/significand form, one register stage.
// Define TO_REC_FN_CANON_NAN_EN to replace every NaN by the canonical quiet NaN.
module to_rec_fn
   import to_rec_fn_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] fp,
   output logic        out_valid,
   output logic        sign,
   output logic [8:0]  exp,
   output logic [31:0] sig,
   output logic        isNAN,
   output logic        isINf,
   output logic        isZero,
   output logic        isNormalize,
   output logic        isUnormalize
);

   logic [EXP_W-1:0]     e;
   logic [FRAC_W-1:0]    f;
   logic [FRAC_W-1:0]    frac_sh;
   logic [4:0]           lz;
   logic                 e_zero, e_max, f_zero;
   logic                 c_nan, c_inf, c_zero, c_norm, c_unorm;
   logic                 rec_sign;
   logic [REC_EXP_W-1:0] rec_exp;
   logic [31:0]          rec_sig;

   logic                 out_valid_d, out_valid_q;
   logic                 sign_d, sign_q;
   logic [REC_EXP_W-1:0] exp_d, exp_q;
   logic [31:0]          sig_d, sig_q;
   logic [4:0]           flags_d, flags_q;

   assign e = fp[30:23];
   assign f = fp[22:0];

   to_rec_fn_lzc u_lzc (
      .f   (f),
      .cnt (lz)
   );

   always_comb begin
      e_zero  = (e == '0);
      e_max   = &e;
      f_zero  = (f == '0);
      c_zero  = e_zero & f_zero;
      c_unorm = e_zero & ~f_zero;
      c_inf   = e_max & f_zero;
      c_nan   = e_max & ~f_zero;
      c_norm  = ~e_zero & ~e_max;

      // Shift out the leading one so it becomes the hidden bit.
      frac_sh  = f << (lz + 5'd1);
      rec_sign = fp[31];
      rec_exp  = '0;
      rec_sig  = '0;
      if (c_norm) begin
         rec_exp = {1'b0, e} + REC_BIAS_ADJ;
         rec_sig = {1'b1, f, 8'h00};
      end else if (c_unorm) begin
         rec_exp = REC_BIAS_ADJ - {4'b0000, lz};
         rec_sig = {1'b1, frac_sh, 8'h00};
      end else if (c_inf) begin
         rec_exp = REC_EXP_INF;
         rec_sig = 32'h8000_0000;
      end else if (c_nan) begin
         rec_exp = REC_EXP_NAN;
`ifdef TO_REC_FN_CANON_NAN_EN
         rec_sign = 1'b0;
         rec_sig  = CANON_NAN_SIG;
`else
         rec_sig  = {1'b1, f, 8'h00};
`endif
      end

      // Data holds across idle cycles; only the valid strobe drops.
      out_valid_d = in_valid;
      sign_d      = sign_q;
      exp_d       = exp_q;
      sig_d       = sig_q;
      flags_d     = flags_q;
      if (in_valid) begin
         sign_d  = rec_sign;
         exp_d   = rec_exp;
         sig_d   = rec_sig;
         flags_d = {c_nan, c_inf, c_zero, c_norm, c_unorm};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         sig_q       <= '0;
         flags_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         sig_q       <= sig_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign sign         = sign_q;
   assign exp          = exp_q;
   assign sig          = sig_q;
   assign isNAN        = flags_q[4];
   assign isINf        = flags_q[3];
   assign isZero       = flags_q[2];
   assign isNormalize  = flags_q[1];
   assign isUnormalize = flags_q[0];

endmodule

// File: tb/tb_to_rec_fn.sv
// Scoreboard bench for to_rec_fn: stimulus queues hand-computed results,
// a monitor compares one queued entry per clock after the edge.
module tb_to_rec_fn;

   typedef struct {
      string       name;
      logic        vld;
      logic        sign;
      logic [8:0]  exp;
      logic [31:0] sig;
      logic [4:0]  flags;   // {nan, inf, zero, norm, unorm}
   } exp_t;

   localparam logic [4:0] F_NAN = 5'b10000, F_INF = 5'b01000, F_ZERO = 5'b00100,
                          F_NORM = 5'b00010, F_UNORM = 5'b00001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] fp = '0;
   logic        out_valid, sign;
   logic [8:0]  exp;
   logic [31:0] sig;
   logic        isNAN, isINf, isZero, isNormalize, isUnormalize;

   exp_t q[$];
   exp_t last;
   int   total = 0;
   int   bad = 0;
   bit   stim_done = 1'b0;

   to_rec_fn dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .fp           (fp),
      .out_valid    (out_valid),
      .sign         (sign),
      .exp          (exp),
      .sig          (sig),
      .isNAN        (isNAN),
      .isINf        (isINf),
      .isZero       (isZero),
      .isNormalize  (isNormalize),
      .isUnormalize (isUnormalize)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(string n, logic s, logic [8:0] e, logic [31:0] g, logic [4:0] fl);
      exp_t r;
      r.name = n; r.vld = 1'b1; r.sign = s; r.exp = e; r.sig = g; r.flags = fl;
      return r;
   endfunction

   task automatic send(input logic [31:0] f, input exp_t r);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; fp = f;
      q.push_back(r);
      last = r;
   endtask

   task automatic gap(input string n);
      exp_t r;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; fp = 32'hDEAD_BEEF;
      r = last; r.name = n; r.vld = 1'b0;
      q.push_back(r);
   endtask

   task automatic reset_cycle(input string n, input logic iv);
      exp_t r;
      @(negedge clk);
      rst = 1'b1; in_valid = iv; fp = 32'h3F80_0000;
      r = mk(n, 1'b0, 9'h000, 32'h0, 5'b0); r.vld = 1'b0;
      q.push_back(r);
      last = r;
   endtask

   // Monitor: one scoreboard entry per clock, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (out_valid !== e.vld || sign !== e.sign || exp !== e.exp || sig !== e.sig ||
                {isNAN, isINf, isZero, isNormalize, isUnormalize} !== e.flags) begin
               bad++;
               $display("FAIL %s: got v=%b s=%b exp=%h sig=%h fl=%b, want v=%b s=%b exp=%h sig=%h fl=%b",
                        e.name, out_valid, sign, exp, sig,
                        {isNAN, isINf, isZero, isNormalize, isUnormalize},
                        e.vld, e.sign, e.exp, e.sig, e.flags);
            end
         end
      end
   end

   initial begin
      @(negedge clk);
      reset_cycle("reset_idle", 1'b0);
      reset_cycle("reset_over_valid", 1'b1);
`ifdef TO_REC_FN_CANON_NAN_EN
      send(32'h7FA00000, mk("nan_payload", 1'b0, 9'h1C0, 32'hC0000000, F_NAN));
`else
      send(32'h7FA00000, mk("nan_payload", 1'b0, 9'h1C0, 32'hA0000000, F_NAN));
`endif
      send(32'h3F800000, mk("one",          1'b0, 9'h100, 32'h80000000, F_NORM));
      send(32'h00000001, mk("sub_min",      1'b0, 9'h06B, 32'h80000000, F_UNORM));
      send(32'h00400000, mk("sub_top",      1'b0, 9'h081, 32'h80000000, F_UNORM));
      send(32'h80000000, mk("neg_zero",     1'b1, 9'h000, 32'h00000000, F_ZERO));
      send(32'hFF800000, mk("neg_inf",      1'b1, 9'h180, 32'h80000000, F_INF));
      gap("gap_hold_inf");
      gap("gap_hold_inf2");
      send(32'h7F800000, mk("pos_inf",      1'b0, 9'h180, 32'h80000000, F_INF));
      send(32'h00000000, mk("pos_zero",     1'b0, 9'h000, 32'h00000000, F_ZERO));
      send(32'hC0490FDB, mk("neg_pi",       1'b1, 9'h101, 32'hC90FDB00, F_NORM));
      send(32'h7F7FFFFF, mk("max_norm",     1'b0, 9'h17F, 32'hFFFFFF00, F_NORM));
      send(32'h00800000, mk("min_norm",     1'b0, 9'h082, 32'h80000000, F_NORM));
      send(32'h807FFFFF, mk("sub_max_neg",  1'b1, 9'h081, 32'hFFFFFE00, F_UNORM));
      send(32'h00000300, mk("sub_mid",      1'b0, 9'h074, 32'hC0000000, F_UNORM));
`ifdef TO_REC_FN_CANON_NAN_EN
      send(32'hFF800001, mk("snan_neg",     1'b0, 9'h1C0, 32'hC0000000, F_NAN));
`else
      send(32'hFF800001, mk("snan_neg",     1'b1, 9'h1C0, 32'h80000100, F_NAN));
`endif
      send(32'h7FC00000, mk("qnan",         1'b0, 9'h1C0, 32'hC0000000, F_NAN));
      gap("gap_hold_nan");
      reset_cycle("reset_midstream", 1'b1);
      send(32'h3F800000, mk("one_after_rst", 1'b0, 9'h100, 32'h80000000, F_NORM));
      gap("gap_final");
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d entries left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1);
   end

endmodule
